// File: rtl/pet_text_renderer_if.sv
// Signal bundle between the VGA timing generator, video RAM, font ROM and the
// PET text renderer. The renderer takes the slave view; the timing/memory side takes the master view.
interface pet_text_renderer_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       h_sync_in;
  logic       v_sync_in;
  logic       blanking_start;
  logic [9:0] vram_addr;
  logic [7:0] vram_data;
  logic [9:0] font_addr;
  logic [7:0] font_data;
  logic       cursor_en;
  logic [9:0] cursor_addr;
  logic       pixel;
  logic       h_sync;
  logic       v_sync;
  logic       de;

  modport slave (
    input  x, y, active, h_sync_in, v_sync_in, blanking_start,
    input  vram_data, font_data, cursor_en, cursor_addr,
    output vram_addr, font_addr, pixel, h_sync, v_sync, de
  );

  modport master (
    output x, y, active, h_sync_in, v_sync_in, blanking_start,
    output vram_data, font_data, cursor_en, cursor_addr,
    input  vram_addr, font_addr, pixel, h_sync, v_sync, de
  );
endinterface

// File: rtl/pet_text_renderer.sv
// 40x25 PET-style text renderer: 5-stage pipeline through synchronous VRAM and
// font ROM, producing a monochrome pixel with syncs/de delayed to match.
module pet_text_renderer #(
  parameter int V_OFFSET     = 40,
  parameter int COLS         = 40,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  pet_text_renderer_if.slave   bus
);

  localparam logic [9:0] Y_LO       = 10'(V_OFFSET);
  localparam logic [9:0] Y_HI       = 10'(V_OFFSET + 400);
  localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

  // Window decode
  logic       in_text;
  logic [9:0] yt;
  logic [4:0] row;
  logic [5:0] col;
  logic [2:0] grow;
  logic [2:0] bsel;
  logic [9:0] cell_addr;

  assign in_text = bus.active && (bus.y >= Y_LO) && (bus.y < Y_HI);
  assign yt      = bus.y - Y_LO;
  assign row     = yt[8:4];
  assign grow    = yt[3:1];
  assign col     = bus.x[9:4];
  assign bsel    = 3'd7 - bus.x[3:1];

  generate
    if (COLS == 40) begin : g_addr40
      assign cell_addr = {row, 5'b0} + {2'b0, row, 3'b0} + {4'b0, col};
    end else begin : g_addr_gen
      assign cell_addr = 10'(row) * 10'(COLS) + {4'b0, col};
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = &{1'b0, yt[9], yt[0], bus.x[0]};

  // Pipeline registers
  logic [9:0] vram_addr_q, vram_addr_d;
  logic [9:0] font_addr_q, font_addr_d;
  logic       pixel_q, pixel_d;

  logic       s1_in_q, s1_in_d, s1_match_q, s1_match_d;
  logic [2:0] s1_bsel_q, s1_bsel_d, s1_grow_q, s1_grow_d;
  logic       s2_in_q, s2_in_d, s2_match_q, s2_match_d;
  logic [2:0] s2_bsel_q, s2_bsel_d, s2_grow_q, s2_grow_d;
  logic       s3_in_q, s3_in_d, s3_match_q, s3_match_d, s3_rev_q, s3_rev_d;
  logic [2:0] s3_bsel_q, s3_bsel_d;
  logic       s4_in_q, s4_in_d, s4_match_q, s4_match_d, s4_rev_q, s4_rev_d;
  logic [2:0] s4_bsel_q, s4_bsel_d;

  logic [4:0] hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [5:0] blink_cnt_q, blink_cnt_d;
  logic       blink_phase_q, blink_phase_d;

  always_comb begin
    // S1: address generation; the address holds outside the window
    vram_addr_d = in_text ? cell_addr : vram_addr_q;
    s1_in_d     = in_text;
    s1_bsel_d   = bsel;
    s1_grow_d   = grow;
    s1_match_d  = (cell_addr == bus.cursor_addr);

    // S2: RAM read in flight
    s2_in_d     = s1_in_q;
    s2_bsel_d   = s1_bsel_q;
    s2_grow_d   = s1_grow_q;
    s2_match_d  = s1_match_q;

    // S3: character code arrives, build glyph row address
    font_addr_d = {bus.vram_data[6:0], s2_grow_q};
    s3_rev_d    = bus.vram_data[7];
    s3_in_d     = s2_in_q;
    s3_bsel_d   = s2_bsel_q;
    s3_match_d  = s2_match_q;

    // S4: ROM read in flight
    s4_in_d     = s3_in_q;
    s4_bsel_d   = s3_bsel_q;
    s4_match_d  = s3_match_q;
    s4_rev_d    = s3_rev_q;

    // S5: reverse video and cursor are both XOR terms, so they cancel on a cursor cell
    pixel_d = s4_in_q & (bus.font_data[s4_bsel_q] ^ s4_rev_q ^
                         (bus.cursor_en & s4_match_q & blink_phase_q));

    hs_d = {hs_q[3:0], bus.h_sync_in};
    vs_d = {vs_q[3:0], bus.v_sync_in};
    de_d = {de_q[3:0], bus.active};

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (bus.blanking_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vram_addr_q   <= '0;
      font_addr_q   <= '0;
      pixel_q       <= 1'b0;
      s1_in_q       <= 1'b0;
      s1_match_q    <= 1'b0;
      s1_bsel_q     <= '0;
      s1_grow_q     <= '0;
      s2_in_q       <= 1'b0;
      s2_match_q    <= 1'b0;
      s2_bsel_q     <= '0;
      s2_grow_q     <= '0;
      s3_in_q       <= 1'b0;
      s3_match_q    <= 1'b0;
      s3_rev_q      <= 1'b0;
      s3_bsel_q     <= '0;
      s4_in_q       <= 1'b0;
      s4_match_q    <= 1'b0;
      s4_rev_q      <= 1'b0;
      s4_bsel_q     <= '0;
      hs_q          <= '1;
      vs_q          <= '1;
      de_q          <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      vram_addr_q   <= vram_addr_d;
      font_addr_q   <= font_addr_d;
      pixel_q       <= pixel_d;
      s1_in_q       <= s1_in_d;
      s1_match_q    <= s1_match_d;
      s1_bsel_q     <= s1_bsel_d;
      s1_grow_q     <= s1_grow_d;
      s2_in_q       <= s2_in_d;
      s2_match_q    <= s2_match_d;
      s2_bsel_q     <= s2_bsel_d;
      s2_grow_q     <= s2_grow_d;
      s3_in_q       <= s3_in_d;
      s3_match_q    <= s3_match_d;
      s3_rev_q      <= s3_rev_d;
      s3_bsel_q     <= s3_bsel_d;
      s4_in_q       <= s4_in_d;
      s4_match_q    <= s4_match_d;
      s4_rev_q      <= s4_rev_d;
      s4_bsel_q     <= s4_bsel_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign bus.vram_addr = vram_addr_q;
  assign bus.font_addr = font_addr_q;
  assign bus.pixel     = pixel_q;
  assign bus.h_sync    = hs_q[4];
  assign bus.v_sync    = vs_q[4];
  assign bus.de        = de_q[4];

endmodule

// File: tb/tb_pet_text_renderer.sv
// Bench for pet_text_renderer: table-driven pixel sweeps and hand sequences,
// with {pixel,de,h_sync,v_sync} expectations queued on drive and checked 5 cycles later.
module tb_pet_text_renderer;

  logic clk;
  logic rst;
  pet_text_renderer_if bus ();

  pet_text_renderer #(.V_OFFSET(40), .COLS(40), .BLINK_FRAMES(30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] vram [1024];
  logic [7:0] font [1024];

  always @(posedge clk) begin
    bus.vram_data <= vram[bus.vram_addr];
    bus.font_data <= font[bus.font_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         due;
    logic [3:0] exp;
    string      tag;
  } sb_t;
  sb_t q[$];

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       pix;
    int         va;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    sb_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk({e.tag, " {pixel,de,hs,vs}"}, 32'({bus.pixel, bus.de, bus.h_sync, bus.v_sync}),
          32'(e.exp));
    end
  end

  // A reset cycle flushes everything still in flight, so queued results become reset values.
  task automatic step(input logic r, input logic [9:0] xx, input logic [9:0] yy,
                      input logic act, input logic hsi, input logic vsi, input logic blk,
                      input logic pix, input string tag);
    sb_t e;
    @(posedge clk);
    #1;
    rst                = r;
    bus.x              = xx;
    bus.y              = yy;
    bus.active         = act;
    bus.h_sync_in      = hsi;
    bus.v_sync_in      = vsi;
    bus.blanking_start = blk;
    if (r) begin
      for (int i = 0; i < q.size(); i++)
        if (q[i].due > cyc) q[i].exp = 4'b0011;
    end
    e.due = cyc + 5;
    e.exp = r ? 4'b0011 : {pix, act, hsi, vsi};
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "idle");
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "pulse");
  endtask

  task automatic add(input int xx, input int yy, input logic act, input logic pix, input int va);
    vec_t v;
    v.x = 10'(xx); v.y = 10'(yy); v.act = act; v.pix = pix; v.va = va;
    tbl.push_back(v);
  endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, tbl[i].x, tbl[i].y, tbl[i].act, 1'b1, 1'b1, 1'b0, tbl[i].pix, tag);
      if (i > 0 && tbl[i-1].va >= 0)
        chk({tag, " vram_addr"}, 32'(bus.vram_addr), 32'(tbl[i-1].va));
    end
    tbl.delete();
    idle(6);
  endtask

  task automatic cursor_cell(input logic pix, input string tag);
    for (int xx = 0; xx < 16; xx++) add(xx, 40, 1'b1, pix, -1);
    add(16, 40, 1'b1, 1'b0, -1);
    run_tbl(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " pixel"},     32'(bus.pixel),     32'(0));
    chk({tag, " de"},        32'(bus.de),        32'(0));
    chk({tag, " h_sync"},    32'(bus.h_sync),    32'(1));
    chk({tag, " v_sync"},    32'(bus.v_sync),    32'(1));
    chk({tag, " vram_addr"}, 32'(bus.vram_addr), 32'(0));
    chk({tag, " font_addr"}, 32'(bus.font_addr), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst                = 1'b1;
    bus.x              = '0;
    bus.y              = '0;
    bus.active         = 1'b0;
    bus.h_sync_in      = 1'b1;
    bus.v_sync_in      = 1'b1;
    bus.blanking_start = 1'b0;
    bus.cursor_en      = 1'b0;
    bus.cursor_addr    = '0;
    for (int i = 0; i < 1024; i++) begin vram[i] = 8'h00; font[i] = 8'h00; end
    vram[0]           = 8'h41;
    vram[999]         = 8'hC1;
    font[10'h41 * 8]  = 8'h81;

    // Reset with random inputs, including stray blanking pulses that must be ignored
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'b0, "reset");
      if (i > 0) chk_reset_outputs("reset");
    end
    idle(1);
    chk_reset_outputs("post_reset");
    idle(6);

    // Last cell, reverse video over an empty glyph row
    for (int xx = 624; xx < 640; xx++) add(xx, 439, 1'b1, 1'b1, (xx == 624) ? 999 : -1);
    run_tbl("last_cell");

    // First cell: glyph row 0x81 doubled horizontally, then blank cell 1 and inactive samples
    for (int xx = 0; xx < 16; xx++) add(xx, 40, 1'b1, (xx < 2 || xx > 13), (xx == 0) ? 0 : -1);
    for (int xx = 16; xx < 32; xx++) add(xx, 40, 1'b1, 1'b0, -1);
    add(0, 40, 1'b0, 1'b0, -1);
    add(14, 41, 1'b0, 1'b0, -1);
    add(1, 41, 1'b1, 1'b1, -1);
    run_tbl("first_cell");

    // Border: solid glyphs everywhere, only the window may light up
    for (int i = 0; i < 1024; i++) begin vram[i] = 8'h7F; font[i] = 8'hFF; end
    for (int xx = 0; xx < 640; xx++) begin
      add(xx, 39, 1'b1, 1'b0, -1);
      add(xx, 440, 1'b1, 1'b0, -1);
      add(xx, 40, 1'b1, 1'b1, -1);
    end
    add(320, 439, 1'b1, 1'b1, -1);
    run_tbl("border");

    // Cursor blink on cell 0 over a blank glyph
    for (int i = 0; i < 1024; i++) begin vram[i] = 8'h00; font[i] = 8'h00; end
    bus.cursor_en   = 1'b1;
    bus.cursor_addr = 10'd0;
    idle(2);
    cursor_cell(1'b1, "cursor_initial");
    pulses(29);
    cursor_cell(1'b1, "cursor_29");
    pulses(1);
    cursor_cell(1'b0, "cursor_30");
    pulses(29);
    cursor_cell(1'b0, "cursor_59");
    pulses(1);
    cursor_cell(1'b1, "cursor_60");
    vram[0] = 8'h80;
    idle(2);
    cursor_cell(1'b0, "cursor_reverse");
    vram[0] = 8'h00;
    bus.cursor_en = 1'b0;
    idle(2);

    // Sync/de alignment with a reset pulse in the middle of the line
    for (int i = 0; i < 30; i++)
      step((i == 12 || i == 13), 10'(i), 10'd300, (i % 5 < 2), (i % 7 < 3), (i % 11 < 5),
           1'b0, 1'b0, "sync");
    idle(8);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
